// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, ALU/condition codes and pipeline register layouts
// used by the execute stage and its ALU.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] CC_RESET = 3'b100;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valC;
      logic [63:0] valA;
      logic [63:0] valB;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } e_reg_t;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } m_reg_t;

   localparam e_reg_t E_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                   valC: 64'h0, valA: 64'h0, valB: 64'h0,
                                   dstE: RNONE, dstM: RNONE};
   localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                   valE: 64'h0, valA: 64'h0,
                                   dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute fields and the M pipeline register outputs. No handshake:
// flow is governed by the stall/bubble controls, and every cycle's d_* is a candidate.
interface execute_stage_if;

   logic [2:0]  d_stat;
   logic [3:0]  d_icode;
   logic [3:0]  d_ifun;
   logic [63:0] d_valA;
   logic [63:0] d_valB;
   logic [63:0] d_valC;
   logic [3:0]  d_dstE;
   logic [3:0]  d_dstM;

   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;

   modport master (
      output d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
      input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
      output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
   );

endinterface

// File: rtl/alu64.sv
// Combinational 64-bit Y86 ALU: valE = aluB op aluA with ZF/SF/OF.
// Codes outside add/sub/and/xor produce zero with OF clear.
module alu64
   import y86_pkg::*;
(
   input  logic [63:0] aluA,
   input  logic [63:0] aluB,
   input  logic [3:0]  alufun,
   output logic [63:0] valE,
   output logic        zf,
   output logic        sf,
   output logic        of
);

   always_comb begin
      valE = '0;
      of   = 1'b0;
      case (alufun)
         ALU_ADD: begin
            valE = aluB + aluA;
            of   = (aluA[63] == aluB[63]) && (valE[63] != aluA[63]);
         end
         ALU_SUB: begin
            valE = aluB - aluA;
            of   = (aluA[63] != aluB[63]) && (valE[63] != aluB[63]);
         end
         ALU_AND: valE = aluB & aluA;
         ALU_XOR: valE = aluB ^ aluA;
         default: valE = '0;
      endcase
   end

   assign zf = (valE == 64'h0);
   assign sf = valE[63];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E register, operand muxes, ALU, condition codes,
// branch/cmov condition and M register launch.
module execute_stage
   import y86_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   e_stall,
   input  logic                   e_bubble,
   input  logic                   m_bubble,
   input  logic                   m_exc,
   input  logic                   w_exc,
   execute_stage_if.slave         bus,
   output logic [63:0]            e_valE,
   output logic [3:0]             e_dstE,
   output logic                   e_cnd,
   output logic [2:0]             cc
);

   e_reg_t      e_q, e_d;
   m_reg_t      m_q, m_d;
   logic [2:0]  cc_q, cc_d;
   logic [63:0] alu_a, alu_b;
   logic [3:0]  alu_fun;
   logic        alu_zf, alu_sf, alu_of;
   logic        set_cc;

   // Bubble wins over stall so a squashed instruction never lingers in E.
   always_comb begin
      e_d = e_q;
      if (e_bubble) begin
         e_d = E_BUBBLE;
      end else if (!e_stall) begin
         e_d = '{stat: bus.d_stat, icode: bus.d_icode, ifun: bus.d_ifun,
                 valC: bus.d_valC, valA: bus.d_valA, valB: bus.d_valB,
                 dstE: bus.d_dstE, dstM: bus.d_dstM};
      end
   end

   always_comb begin
      alu_a   = 64'h0;
      alu_b   = 64'h0;
      alu_fun = (e_q.icode == I_OPQ) ? e_q.ifun : ALU_ADD;
      case (e_q.icode)
         I_RRMOVQ, I_OPQ:             alu_a = e_q.valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.valC;
         I_CALL, I_PUSHQ:             alu_a = -64'd8;
         I_RET, I_POPQ:               alu_a = 64'd8;
         I_HALT, I_NOP, I_JXX:        alu_a = 64'h0;
         default:                     alu_a = 64'h0;
      endcase
      case (e_q.icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
         I_PUSHQ, I_RET, I_POPQ:      alu_b = e_q.valB;
         default:                     alu_b = 64'h0;
      endcase
   end

   alu64 u_alu (
      .aluA   (alu_a),
      .aluB   (alu_b),
      .alufun (alu_fun),
      .valE   (e_valE),
      .zf     (alu_zf),
      .sf     (alu_sf),
      .of     (alu_of)
   );

   // Condition is judged on the flags already latched, not this cycle's ALU output.
   always_comb begin
      e_cnd = 1'b0;
      case (e_q.ifun)
         C_YES:   e_cnd = 1'b1;
         C_LE:    e_cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         C_L:     e_cnd = cc_q[1] ^ cc_q[0];
         C_E:     e_cnd = cc_q[2];
         C_NE:    e_cnd = !cc_q[2];
         C_GE:    e_cnd = !(cc_q[1] ^ cc_q[0]);
         C_G:     e_cnd = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
         default: e_cnd = 1'b0;
      endcase
   end

   assign e_dstE = ((e_q.icode == I_RRMOVQ) && !e_cnd) ? RNONE : e_q.dstE;
   assign set_cc = (e_q.icode == I_OPQ) && !m_exc && !w_exc;
   assign cc_d   = set_cc ? {alu_zf, alu_sf, alu_of} : cc_q;

   always_comb begin
      m_d = '{stat: e_q.stat, icode: e_q.icode, cnd: e_cnd, valE: e_valE,
              valA: e_q.valA, dstE: e_dstE, dstM: e_q.dstM};
      if (m_bubble) m_d = M_BUBBLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q  <= E_BUBBLE;
         m_q  <= M_BUBBLE;
         cc_q <= CC_RESET;
      end else begin
         e_q  <= e_d;
         m_q  <= m_d;
         cc_q <= cc_d;
      end
   end

   assign cc          = cc_q;
   assign bus.M_stat  = m_q.stat;
   assign bus.M_icode = m_q.icode;
   assign bus.M_cnd   = m_q.cnd;
   assign bus.M_valE  = m_q.valE;
   assign bus.M_valA  = m_q.valA;
   assign bus.M_dstE  = m_q.dstE;
   assign bus.M_dstM  = m_q.dstM;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against an instruction-level
// model of the Y86-64 execute semantics.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        e_stall, e_bubble, m_bubble, m_exc, w_exc;
   logic [63:0] e_valE;
   logic [3:0]  e_dstE;
   logic        e_cnd;
   logic [2:0]  cc;

   execute_stage_if bus();

   execute_stage dut (
      .clk      (clk),
      .rst      (rst),
      .e_stall  (e_stall),
      .e_bubble (e_bubble),
      .m_bubble (m_bubble),
      .m_exc    (m_exc),
      .w_exc    (w_exc),
      .bus      (bus),
      .e_valE   (e_valE),
      .e_dstE   (e_dstE),
      .e_cnd    (e_cnd),
      .cc       (cc)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode, ifun;
      logic [63:0] valA, valB, valC;
      logic [3:0]  dstE, dstM;
   } ins_t;

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valE, valA;
      logic [3:0]  dstE, dstM;
   } mres_t;

   typedef struct {
      logic [63:0] valE;
      logic [2:0]  flags;
      logic        cnd;
      logic [3:0]  dstE;
   } exe_t;

   ins_t       mdl_e;
   mres_t      mdl_m;
   logic [2:0] mdl_cc;

   function automatic ins_t nop_ins();
      ins_t i;
      i.stat = 3'd1; i.icode = 4'd1; i.ifun = 4'd0;
      i.valA = 64'd0; i.valB = 64'd0; i.valC = 64'd0;
      i.dstE = 4'hF; i.dstM = 4'hF;
      return i;
   endfunction

   function automatic mres_t nop_m();
      mres_t m;
      m.stat = 3'd1; m.icode = 4'd1; m.cnd = 1'b0;
      m.valE = 64'd0; m.valA = 64'd0; m.dstE = 4'hF; m.dstM = 4'hF;
      return m;
   endfunction

   // Instruction semantics: overflow taken from a 65-bit signed result.
   function automatic exe_t model_exe(input ins_t i, input logic [2:0] c);
      exe_t        r;
      logic [63:0] a, b;
      logic [64:0] s;
      logic        of, zf, sf, o;
      case (i.icode)
         4'd2, 4'd6:       a = i.valA;
         4'd3, 4'd4, 4'd5: a = i.valC;
         4'd8, 4'd10:      a = 64'hFFFF_FFFF_FFFF_FFF8;
         4'd9, 4'd11:      a = 64'd8;
         default:          a = 64'd0;
      endcase
      case (i.icode)
         4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: b = i.valB;
         default: b = 64'd0;
      endcase
      of = 1'b0;
      if (i.icode == 4'd6) begin
         case (i.ifun)
            4'd0: begin s = {b[63], b} + {a[63], a}; r.valE = s[63:0]; of = s[64] ^ s[63]; end
            4'd1: begin s = {b[63], b} - {a[63], a}; r.valE = s[63:0]; of = s[64] ^ s[63]; end
            4'd2: r.valE = a & b;
            4'd3: r.valE = a ^ b;
            default: r.valE = 64'd0;
         endcase
      end else begin
         r.valE = a + b;
      end
      r.flags = {r.valE == 64'd0, r.valE[63], of};
      zf = c[2]; sf = c[1]; o = c[0];
      case (i.ifun)
         4'd0: r.cnd = 1'b1;
         4'd1: r.cnd = (sf ^ o) | zf;
         4'd2: r.cnd = sf ^ o;
         4'd3: r.cnd = zf;
         4'd4: r.cnd = !zf;
         4'd5: r.cnd = !(sf ^ o);
         4'd6: r.cnd = !(sf ^ o) && !zf;
         default: r.cnd = 1'b0;
      endcase
      r.dstE = (i.icode == 4'd2 && !r.cnd) ? 4'hF : i.dstE;
      return r;
   endfunction

   task automatic model_reset();
      mdl_e  = nop_ins();
      mdl_m  = nop_m();
      mdl_cc = 3'b100;
   endtask

   task automatic model_edge();
      exe_t  x;
      ins_t  ne;
      mres_t nm;
      x = model_exe(mdl_e, mdl_cc);
      if (m_bubble) nm = nop_m();
      else begin
         nm.stat = mdl_e.stat; nm.icode = mdl_e.icode; nm.cnd = x.cnd;
         nm.valE = x.valE; nm.valA = mdl_e.valA; nm.dstE = x.dstE; nm.dstM = mdl_e.dstM;
      end
      if (mdl_e.icode == 4'd6 && !m_exc && !w_exc) mdl_cc = x.flags;
      if (e_bubble) ne = nop_ins();
      else if (e_stall) ne = mdl_e;
      else begin
         ne.stat = bus.d_stat; ne.icode = bus.d_icode; ne.ifun = bus.d_ifun;
         ne.valA = bus.d_valA; ne.valB = bus.d_valB; ne.valC = bus.d_valC;
         ne.dstE = bus.d_dstE; ne.dstM = bus.d_dstM;
      end
      mdl_e = ne;
      mdl_m = nm;
   endtask

   always @(negedge clk) begin : compare
      exe_t x;
      if (!rst) begin
         x = model_exe(mdl_e, mdl_cc);
         check("e_valE", e_valE, x.valE);
         check("e_dstE", {60'd0, e_dstE}, {60'd0, x.dstE});
         check("e_cnd", {63'd0, e_cnd}, {63'd0, x.cnd});
         check("cc", {61'd0, cc}, {61'd0, mdl_cc});
         check("M_stat", {61'd0, bus.M_stat}, {61'd0, mdl_m.stat});
         check("M_icode", {60'd0, bus.M_icode}, {60'd0, mdl_m.icode});
         check("M_cnd", {63'd0, bus.M_cnd}, {63'd0, mdl_m.cnd});
         check("M_valE", bus.M_valE, mdl_m.valE);
         check("M_valA", bus.M_valA, mdl_m.valA);
         check("M_dstE", {60'd0, bus.M_dstE}, {60'd0, mdl_m.dstE});
         check("M_dstM", {60'd0, bus.M_dstM}, {60'd0, mdl_m.dstM});
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb,
                        input logic [63:0] vc, input logic [3:0] de);
      bus.d_stat  = 3'd1;
      bus.d_icode = icode;
      bus.d_ifun  = ifun;
      bus.d_valA  = va;
      bus.d_valB  = vb;
      bus.d_valC  = vc;
      bus.d_dstE  = de;
      bus.d_dstM  = 4'hF;
   endtask

   function automatic logic [63:0] rand64();
      case ($urandom_range(0, 4))
         0: return 64'd0;
         1: return 64'h8000_0000_0000_0000;
         2: return 64'hFFFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic check_reset_state();
      check("rst_M_icode", {60'd0, bus.M_icode}, 64'd1);
      check("rst_M_stat", {61'd0, bus.M_stat}, 64'd1);
      check("rst_M_dstE", {60'd0, bus.M_dstE}, 64'hF);
      check("rst_M_dstM", {60'd0, bus.M_dstM}, 64'hF);
      check("rst_cc", {61'd0, cc}, 64'h4);
   endtask

   initial begin
      rst = 1'b1;
      e_stall = 1'b0; e_bubble = 1'b0; m_bubble = 1'b0; m_exc = 1'b0; w_exc = 1'b0;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      model_reset();
      #2;
      check_reset_state();
      #10 rst = 1'b0;

      // XOR and subtract-overflow feeding cmovle / cmove
      drive(4'd6, 4'd3, 64'h26, 64'h31, 64'd0, 4'd1);
      cycle();
      check("xor_e_valE", e_valE, 64'h17);
      drive(4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'd1);
      cycle();
      check("xor_M_valE", bus.M_valE, 64'h17);
      check("xor_cc", {61'd0, cc}, 64'h0);
      check("sub_e_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
      drive(4'd2, 4'd1, 64'h55, 64'd0, 64'd0, 4'd3);
      cycle();
      check("sub_cc", {61'd0, cc}, 64'h1);
      check("cmovle_e_cnd", {63'd0, e_cnd}, 64'd1);
      drive(4'd2, 4'd3, 64'h66, 64'd0, 64'd0, 4'd3);
      cycle();
      check("cmovle_M_dstE", {60'd0, bus.M_dstE}, 64'd3);
      check("cmove_e_cnd", {63'd0, e_cnd}, 64'd0);
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      check("cmove_M_dstE", {60'd0, bus.M_dstE}, 64'hF);
      check("cmove_M_cnd", {63'd0, bus.M_cnd}, 64'd0);

      // CC suppression by m_exc, then normal update
      drive(4'd6, 4'd0, 64'd0, 64'd0, 64'd0, 4'd4);
      cycle();
      m_exc = 1'b1;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      m_exc = 1'b0;
      check("exc_M_valE", bus.M_valE, 64'd0);
      check("exc_M_icode", {60'd0, bus.M_icode}, 64'd6);
      check("exc_cc_held", {61'd0, cc}, 64'h1);
      drive(4'd6, 4'd0, 64'd0, 64'd0, 64'd0, 4'd4);
      cycle();
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      check("noexc_cc", {61'd0, cc}, 64'h4);

      // Stall holds E for N+1 launches into M
      drive(4'd3, 4'd0, 64'd0, 64'd0, 64'd5, 4'd2);
      cycle();
      e_stall = 1'b1;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) e_stall = 1'b0;
         cycle();
         check("stall_M_icode", {60'd0, bus.M_icode}, 64'd3);
         check("stall_M_valE", bus.M_valE, 64'd5);
      end
      e_bubble = 1'b1;
      drive(4'd3, 4'd0, 64'd0, 64'd0, 64'd9, 4'd2);
      cycle();
      e_bubble = 1'b0;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      check("bubble_M_icode", {60'd0, bus.M_icode}, 64'd1);

      // Simultaneous stall and bubble: bubble wins
      drive(4'd3, 4'd0, 64'd0, 64'd0, 64'd7, 4'd2);
      cycle();
      e_stall = 1'b1; e_bubble = 1'b1;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      e_stall = 1'b0; e_bubble = 1'b0;
      check("sb_M_valE", bus.M_valE, 64'd7);
      cycle();
      check("sb_M_icode", {60'd0, bus.M_icode}, 64'd1);

      // M bubble squashes the launch
      drive(4'd3, 4'd0, 64'd0, 64'd0, 64'd5, 4'd2);
      cycle();
      m_bubble = 1'b1;
      drive(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF);
      cycle();
      m_bubble = 1'b0;
      check("mbub_M_icode", {60'd0, bus.M_icode}, 64'd1);
      check("mbub_M_dstE", {60'd0, bus.M_dstE}, 64'hF);

      // Random traffic with an asynchronous reset in the middle
      for (int n = 0; n < 400; n++) begin
         bus.d_stat  = 3'($urandom_range(0, 4));
         bus.d_icode = 4'($urandom_range(0, 11));
         bus.d_ifun  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15))
                                                   : 4'($urandom_range(0, 6));
         bus.d_valA  = rand64();
         bus.d_valB  = rand64();
         bus.d_valC  = rand64();
         bus.d_dstE  = 4'($urandom_range(0, 15));
         bus.d_dstM  = 4'($urandom_range(0, 15));
         e_stall  = ($urandom_range(0, 7) == 0);
         e_bubble = ($urandom_range(0, 11) == 0);
         m_bubble = ($urandom_range(0, 11) == 0);
         m_exc    = ($urandom_range(0, 9) == 0);
         w_exc    = ($urandom_range(0, 9) == 0);
         if (n == 200) begin
            #1 rst = 1'b1;
            #1 check_reset_state();
            model_reset();
            #1 rst = 1'b0;
         end
         cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipelined Y86-64 execute stage: owns the E pipeline register, selects ALU operands, computes valE and flags through the 64-bit ALU (add/sub/and/xor), maintains the condition-code register, evaluates jXX/cmovXX conditions, and launches results into the M pipeline register. It sits between decode (upstream) and memory (downstream). It also exports combinational e_valE/e_dstE for forwarding back to decode.

## Interface
- No parameters; widths fixed by the Y86-64 ISA (64-bit data, 4-bit icode/ifun/register IDs, 3-bit stat).
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- e_stall  input  1  hold E register contents
- e_bubble  input  1  load NOP bubble into E
- m_bubble  input  1  load NOP bubble into M
- m_exc  input  1  exception in memory stage; suppresses CC update
- w_exc  input  1  exception in write-back stage; suppresses CC update
- d_stat, d_icode, d_ifun  input  3/4/4  decoded instruction fields
- d_valA, d_valB, d_valC  input  64 each  operands from decode
- d_dstE, d_dstM  input  4 each  destination register IDs
- e_valE  output  64  combinational ALU result (forwarding)
- e_dstE  output  4  combinational dstE after cmov gating
- e_cnd  output  1  combinational condition result
- cc  output  3  {ZF,SF,OF} register
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  output  3/4/1/64/64/4/4  M register

## Operation
- Icodes: HALT 0, NOP 1, RRMOVQ/CMOV 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RNONE = 0xF. Stat AOK = 1.
- aluA: valA for RRMOVQ and OPQ; valC for IRMOVQ, RMMOVQ, MRMOVQ; -8 for CALL and PUSHQ; +8 for RET and POPQ; 0 otherwise.
- aluB: valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ; 0 for RRMOVQ and IRMOVQ.
- alufun: ifun for OPQ (0 add, 1 sub, 2 and, 3 xor); add otherwise. Undefined OPQ ifun yields valE = 0.
- valE = aluB op aluA. Sub is aluB - aluA. All arithmetic is mod 2^64.
- Flags: ZF = (valE == 0); SF = valE[63].
- OF for add: aluA[63]==aluB[63] && valE[63]!=aluA[63].
- OF for sub: aluA[63]!=aluB[63] && valE[63]!=aluB[63].
- OF for and/xor: 0.
- set_cc = (E_icode == OPQ) && !m_exc && !w_exc. CC loads new flags only when set_cc is high.
- e_cnd from current cc:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): !ZF
  - ifun 5 (ge): !(SF^OF)
  - ifun 6 (g): !(SF^OF)&!ZF
  - ifun ≥ 7: 0
- e_dstE = RNONE when E_icode == RRMOVQ and !e_cnd; otherwise E_dstE.
- M register captures {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM}.
- E-register priority: e_bubble > e_stall > load.
- M register: m_bubble > load. M is never stalled.
- Bubble contents: stat AOK, icode NOP, ifun 0, cnd 0, all values 0, dstE/dstM RNONE.

## Timing
- Reset (async, any time including mid-instruction): E and M registers take bubble contents; cc = 3'b100 (ZF=1, SF=0, OF=0). Effective immediately, not at the next edge.
- E captures decode fields at rising clk. e_valE, e_dstE and e_cnd settle combinationally from E and cc in the same cycle.
- CC and M both update at the following rising edge. Latency from decode inputs to M outputs: 2 edges.
- e_cnd uses pre-update cc. An OPQ followed directly by cmov/jXX sees the OPQ's flags, because the CC update lands at the edge the OPQ leaves E.
- m_exc/w_exc are sampled at the same edge as the CC update. If asserted, cc holds its old value while M still loads normally.
- e_stall held N cycles: M receives the same instruction N+1 times. CC re-updates each time if the instruction is OPQ and no exception is present.

## Structure
- Shared package y86_pkg holds:
  - icode constants
  - ALU function codes
  - condition ifun codes
  - RNONE
  - stat codes
  - bubble-value constants
- One combinational sub-module, alu64: inputs aluA, aluB, alufun; outputs valE, zf, sf, of.
- Operand muxes, CC register, condition logic and both pipeline registers live in execute_stage.

## Test plan
- Reset: pulse rst asynchronously mid-stream → M_icode=1, M_stat=1, M_dstE=M_dstM=0xF, cc=3'b100 before the next clock edge.
- XOR: OPQ ifun 3, valB=0x31, valA=0x26 → e_valE=0x17. After the next edge: M_valE=0x17, cc=3'b000.
- Sub overflow: OPQ ifun 1, valB=0x8000_0000_0000_0000, valA=1 → valE=0x7FFF_FFFF_FFFF_FFFF, cc=3'b001. Next instruction cmovle (ifun 1), dstE=3 → e_cnd=1, M_dstE=3.
- cmove with ZF=0 (cc=3'b001), dstE=3 → e_cnd=0, M_dstE=0xF, M_cnd=0.
- CC suppression: OPQ add, valA=valB=0 with m_exc=1 → M_valE=0, cc unchanged. Repeat with m_exc=0 → cc=3'b100.
- Stall/bubble: e_stall high 2 cycles on IRMOVQ valC=5 → M shows IRMOVQ valE=5 for 3 consecutive cycles. Then e_bubble=1 → M_icode=NOP one cycle later. Simultaneous e_stall=e_bubble=1 → bubble.
